// File: rtl/axi_addr_demux_pkg.sv
// AXI4 channel bundles shared by the address demux and its bench.
package axi_addr_demux_pkg;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/axi_addr_demux.sv
// AXI4 1-to-N address demux. AR and AW are decoded independently; each
// channel tracks outstanding transactions to a single latched target and
// answers unmapped addresses with an internal DECERR.
module axi_addr_demux
    import axi_addr_demux_pkg::*;
#(
    parameter int                      N_SLAVES        = 3,
    parameter logic [N_SLAVES*32-1:0]  SLV_BASE        = {32'h2000_0000, 32'h1000_0000, 32'h8000_0000},
    parameter logic [N_SLAVES*32-1:0]  SLV_MASK        = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000},
    parameter int                      MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  s_axi_mosi_t                  mst_axi_mosi_i,
    output s_axi_miso_t                  mst_axi_miso_o,
    output s_axi_mosi_t [N_SLAVES-1:0]   slv_axi_mosi_o,
    input  s_axi_miso_t [N_SLAVES-1:0]   slv_axi_miso_i
);

    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

    localparam logic [1:0] R_IDLE = 2'd0, R_BUSY = 2'd1, R_ERR = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_BUSY = 2'd1, W_ERR = 2'd2;

    s_axi_mosi_t m;
    assign m = mst_axi_mosi_i;

    logic [1:0]    rstate, wstate;
    logic [CW-1:0] rcnt, wcnt, rcnt_nxt, wcnt_nxt;
    logic [SW-1:0] rsel, wsel, ar_tgt, aw_tgt, w_tgt;
    logic [3:0]    rid_q, wid_q;
    logic [7:0]    rlen_q, rbeat;
    logic          werr_b;
    logic          ar_hit, aw_hit, ar_fwd, aw_fwd, ar_err, aw_err;
    logic          ar_hs, aw_hs, r_done, b_done, w_route;

    s_axi_miso_t                mst_c;
    s_axi_mosi_t [N_SLAVES-1:0] slv_c;

    // Address decode: scan high to low so the lowest matching index wins.
    always_comb begin
        ar_hit = 1'b0;
        ar_tgt = '0;
        aw_hit = 1'b0;
        aw_tgt = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m.araddr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                ar_hit = 1'b1;
                ar_tgt = SW'(i);
            end
            if ((m.awaddr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                aw_hit = 1'b1;
                aw_tgt = SW'(i);
            end
        end
    end

    // Accept/stall qualification and counter next-values for both channels.
    always_comb begin
        ar_fwd   = m.arvalid & ar_hit &
                   ((rstate == R_IDLE) |
                    ((rstate == R_BUSY) & (ar_tgt == rsel) & (rcnt < CMAX)));
        ar_err   = (rstate == R_IDLE) & m.arvalid & ~ar_hit;
        ar_hs    = ar_fwd & slv_axi_miso_i[ar_tgt].arready;
        r_done   = (rstate == R_BUSY) & slv_axi_miso_i[rsel].rvalid &
                   m.rready & slv_axi_miso_i[rsel].rlast;
        rcnt_nxt = rcnt + CW'(ar_hs) - CW'(r_done);

        aw_fwd   = m.awvalid & aw_hit &
                   ((wstate == W_IDLE) |
                    ((wstate == W_BUSY) & (aw_tgt == wsel) & (wcnt < CMAX)));
        aw_err   = (wstate == W_IDLE) & m.awvalid & ~aw_hit;
        aw_hs    = aw_fwd & slv_axi_miso_i[aw_tgt].awready;
        b_done   = (wstate == W_BUSY) & slv_axi_miso_i[wsel].bvalid & m.bready;
        wcnt_nxt = wcnt + CW'(aw_hs) - CW'(b_done);

        // W may arrive with its AW while idle; afterwards it follows wsel.
        w_route  = (wstate == W_BUSY) | ((wstate == W_IDLE) & m.awvalid & aw_hit);
        w_tgt    = (wstate == W_BUSY) ? wsel : aw_tgt;
    end

    // Combinational routing; everything not explicitly driven stays zero.
    always_comb begin
        mst_c = '0;
        slv_c = '0;

        if (ar_fwd) begin
            slv_c[ar_tgt].arid    = m.arid;
            slv_c[ar_tgt].araddr  = m.araddr;
            slv_c[ar_tgt].arlen   = m.arlen;
            slv_c[ar_tgt].arvalid = 1'b1;
            mst_c.arready         = slv_axi_miso_i[ar_tgt].arready;
        end else if (ar_err) begin
            mst_c.arready = 1'b1;
        end

        if (rstate == R_BUSY) begin
            mst_c.rid            = slv_axi_miso_i[rsel].rid;
            mst_c.rdata          = slv_axi_miso_i[rsel].rdata;
            mst_c.rresp          = slv_axi_miso_i[rsel].rresp;
            mst_c.rlast          = slv_axi_miso_i[rsel].rlast;
            mst_c.rvalid         = slv_axi_miso_i[rsel].rvalid;
            slv_c[rsel].rready   = m.rready;
        end else if (rstate == R_ERR) begin
            mst_c.rid    = rid_q;
            mst_c.rresp  = 2'b11;
            mst_c.rlast  = (rbeat == rlen_q);
            mst_c.rvalid = 1'b1;
        end

        if (aw_fwd) begin
            slv_c[aw_tgt].awid    = m.awid;
            slv_c[aw_tgt].awaddr  = m.awaddr;
            slv_c[aw_tgt].awlen   = m.awlen;
            slv_c[aw_tgt].awvalid = 1'b1;
            mst_c.awready         = slv_axi_miso_i[aw_tgt].awready;
        end else if (aw_err) begin
            mst_c.awready = 1'b1;
        end

        if (w_route) begin
            slv_c[w_tgt].wdata  = m.wdata;
            slv_c[w_tgt].wstrb  = m.wstrb;
            slv_c[w_tgt].wlast  = m.wlast;
            slv_c[w_tgt].wvalid = m.wvalid;
            mst_c.wready        = slv_axi_miso_i[w_tgt].wready;
        end else if ((wstate == W_ERR) && !werr_b) begin
            mst_c.wready = 1'b1;
        end

        if (wstate == W_BUSY) begin
            mst_c.bid          = slv_axi_miso_i[wsel].bid;
            mst_c.bresp        = slv_axi_miso_i[wsel].bresp;
            mst_c.bvalid       = slv_axi_miso_i[wsel].bvalid;
            slv_c[wsel].bready = m.bready;
        end else if ((wstate == W_ERR) && werr_b) begin
            mst_c.bid    = wid_q;
            mst_c.bresp  = 2'b11;
            mst_c.bvalid = 1'b1;
        end
    end

    // Outputs are forced quiet while reset is asserted.
    assign mst_axi_miso_o = rst ? mst_c : '0;
    assign slv_axi_mosi_o = rst ? slv_c : '0;

    // Read tracker: target latch, outstanding count and DECERR beat generator.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rstate <= R_IDLE;
            rcnt   <= '0;
            rsel   <= '0;
            rid_q  <= '0;
            rlen_q <= '0;
            rbeat  <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rsel   <= ar_tgt;
                        rcnt   <= CW'(1);
                        rstate <= R_BUSY;
                    end else if (ar_err) begin
                        rid_q  <= m.arid;
                        rlen_q <= m.arlen;
                        rbeat  <= '0;
                        rstate <= R_ERR;
                    end
                end
                R_BUSY: begin
                    rcnt <= rcnt_nxt;
                    if (rcnt_nxt == '0) rstate <= R_IDLE;
                end
                R_ERR: begin
                    if (m.rready) begin
                        if (rbeat == rlen_q) rstate <= R_IDLE;
                        else                 rbeat  <= rbeat + 8'd1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Write tracker: target latch, outstanding count and DECERR drain/response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wstate <= W_IDLE;
            wcnt   <= '0;
            wsel   <= '0;
            wid_q  <= '0;
            werr_b <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        wsel   <= aw_tgt;
                        wcnt   <= CW'(1);
                        wstate <= W_BUSY;
                    end else if (aw_err) begin
                        wid_q  <= m.awid;
                        werr_b <= 1'b0;
                        wstate <= W_ERR;
                    end
                end
                W_BUSY: begin
                    wcnt <= wcnt_nxt;
                    if (wcnt_nxt == '0) wstate <= W_IDLE;
                end
                W_ERR: begin
                    if (!werr_b) begin
                        if (m.wvalid && m.wlast) werr_b <= 1'b1;
                    end else if (m.bready) begin
                        werr_b <= 1'b0;
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_addr_demux.sv
// Self-checking bench for axi_addr_demux: behavioural slaves driven from
// tasks, expectations from an address-range map and an ID queue.
module tb_axi_addr_demux;
    import axi_addr_demux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    s_axi_mosi_t       m;
    s_axi_miso_t       mo;
    s_axi_mosi_t [2:0] so;
    s_axi_miso_t [2:0] s;
    int checks = 0;
    int errors = 0;

    axi_addr_demux dut (
        .clk(clk), .rst(rst),
        .mst_axi_mosi_i(m), .mst_axi_miso_o(mo),
        .slv_axi_mosi_o(so), .slv_axi_miso_i(s)
    );

    always #5 clk = ~clk;

    // Address map expressed as plain ranges, -1 = unmapped.
    function automatic int exp_tgt(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h8000_FFFF) return 0;
        if (a >= 32'h1000_0000 && a <  32'h2000_0000) return 1;
        if (a >= 32'h2000_0000 && a <  32'h3000_0000) return 2;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        m = '0;
        s = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m = '0; m.arvalid = 1'b1; m.araddr = 32'h8000_0000;
        m.awvalid = 1'b1; m.awaddr = 32'h4000_0000; m.wvalid = 1'b1; m.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s[i] = s_axi_miso_t'({$urandom, $urandom, $urandom});
            s[i].arready = 1'b1; s[i].rvalid = 1'b1;
        end
        tick(); tick();
        checks++; if (mo !== '0) begin errors++; $display("FAIL reset_mst got %h exp 0", mo); end
        checks++; if (so !== '0) begin errors++; $display("FAIL reset_slv got %h exp 0", so); end
        checks++; if (int'(dut.rcnt) != 0) begin errors++; $display("FAIL reset_rcnt got %0d exp 0", dut.rcnt); end
        clear();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] ra, wa;
        logic        rr, wr;
        int          rt, wt;
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 4))
                    0: wa = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
                    1: wa = 32'h1000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                    2: wa = 32'h2000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                    3: wa = 32'h8001_0000 | ($urandom & 32'h0000_FFFF);
                    default: wa = 32'h4000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                endcase
                if (k == 0) ra = wa;
            end
            rr = 1'($urandom); wr = 1'($urandom);
            rt = exp_tgt(ra); wt = exp_tgt(wa);
            m.arvalid = 1'b1; m.araddr = ra; m.arid = 4'($urandom);
            m.awvalid = 1'b1; m.awaddr = wa; m.wvalid = 1'b1; m.wdata = $urandom;
            for (int i = 0; i < 3; i++) begin
                s[i].arready = rr; s[i].awready = 1'b0; s[i].wready = wr;
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (so[i].arvalid !== (i == rt) || (i == rt && so[i].araddr !== ra)) begin
                    errors++; $display("FAIL dec_ar slv%0d addr %h got %b exp %b", i, ra, so[i].arvalid, i == rt);
                end
                checks++;
                if (so[i].awvalid !== (i == wt) || so[i].wvalid !== (i == wt)) begin
                    errors++; $display("FAIL dec_aw slv%0d addr %h got %b/%b exp %b", i, wa, so[i].awvalid, so[i].wvalid, i == wt);
                end
            end
            checks++;
            if (mo.arready !== ((rt < 0) ? 1'b1 : rr)) begin
                errors++; $display("FAIL dec_arready addr %h got %b exp %b", ra, mo.arready, (rt < 0) ? 1'b1 : rr);
            end
            checks++;
            if (mo.wready !== ((wt < 0) ? 1'b0 : wr)) begin
                errors++; $display("FAIL dec_wready addr %h got %b exp %b", wa, mo.wready, (wt < 0) ? 1'b0 : wr);
            end
            clear();
            tick();
        end
    endtask

    task automatic test_read(input logic [31:0] addr, input int tgt);
        logic [31:0] d  = $urandom;
        logic [3:0]  id = 4'($urandom);
        m.arvalid = 1'b1; m.araddr = addr; m.arid = id;
        s[tgt].arready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (so[i].arvalid !== (i == tgt)) begin
                errors++; $display("FAIL rd_arvalid slv%0d got %b exp %b", i, so[i].arvalid, i == tgt);
            end
        end
        tick();
        m.arvalid = 1'b0; s[tgt].arready = 1'b0;
        s[tgt].rvalid = 1'b1; s[tgt].rdata = d; s[tgt].rid = id; s[tgt].rlast = 1'b1;
        m.rready = 1'b1;
        #1;
        checks++;
        if (mo.rvalid !== 1'b1 || mo.rdata !== d || mo.rresp !== 2'b00 || mo.rid !== id) begin
            errors++; $display("FAIL rd_data got %b %h %b %h exp 1 %h 00 %h", mo.rvalid, mo.rdata, mo.rresp, mo.rid, d, id);
        end
        tick();
        clear();
        #1;
        checks++;
        if (int'(dut.rcnt) != 0 || mo.rvalid !== 1'b0) begin
            errors++; $display("FAIL rd_done rcnt %0d rvalid %b exp 0 0", dut.rcnt, mo.rvalid);
        end
    endtask

    task automatic test_write();
        logic [3:0] id = 4'($urandom);
        m.awvalid = 1'b1; m.awaddr = 32'h1000_0004; m.awid = id;
        m.wvalid = 1'b1; m.wdata = 32'h1234; m.wstrb = 4'hF; m.wlast = 1'b1;
        s[1].awready = 1'b1; s[1].wready = 1'b1;
        #1;
        checks++;
        if (so[1].awvalid !== 1'b1 || so[1].wvalid !== 1'b1 || so[1].wdata !== 32'h1234) begin
            errors++; $display("FAIL wr_slv1 got %b %b %h exp 1 1 1234", so[1].awvalid, so[1].wvalid, so[1].wdata);
        end
        checks++;
        if ({so[0].awvalid, so[0].wvalid, so[2].awvalid, so[2].wvalid} !== 4'b0) begin
            errors++; $display("FAIL wr_others got %b%b%b%b exp 0000", so[0].awvalid, so[0].wvalid, so[2].awvalid, so[2].wvalid);
        end
        checks++;
        if (mo.awready !== 1'b1 || mo.wready !== 1'b1) begin
            errors++; $display("FAIL wr_ready got %b %b exp 1 1", mo.awready, mo.wready);
        end
        tick();
        clear();
        s[1].bvalid = 1'b1; s[1].bid = id; s[1].bresp = 2'b00; m.bready = 1'b1;
        #1;
        checks++;
        if (mo.bvalid !== 1'b1 || mo.bid !== id || mo.bresp !== 2'b00) begin
            errors++; $display("FAIL wr_b got %b %h %b exp 1 %h 00", mo.bvalid, mo.bid, mo.bresp, id);
        end
        tick();
        clear();
        #1;
        checks++;
        if (int'(dut.wcnt) != 0 || mo.bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_wcnt got %0d %b exp 0 0", dut.wcnt, mo.bvalid);
        end
    endtask

    task automatic test_outstanding();
        logic [3:0] q[$];
        logic [3:0] nid = 4'd1;
        logic       exp_rdy;
        s[0].arready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            m.arvalid = 1'b1; m.araddr = 32'h8000_0000 | ($urandom & 32'hFFFF); m.arid = nid;
            #1;
            exp_rdy = (q.size() < 4);
            checks++;
            if (mo.arready !== exp_rdy) begin
                errors++; $display("FAIL os_arready cyc %0d got %b exp %b", c, mo.arready, exp_rdy);
            end
            tick();
            if (exp_rdy) begin q.push_back(nid); nid++; end
        end
        s[0].rvalid = 1'b1; s[0].rid = q[0]; s[0].rlast = 1'b1; s[0].rdata = $urandom; m.rready = 1'b1;
        #1;
        checks++;
        if (mo.arready !== 1'b0 || mo.rid !== q[0]) begin
            errors++; $display("FAIL os_full arready %b rid %h exp 0 %h", mo.arready, mo.rid, q[0]);
        end
        tick();
        void'(q.pop_front());
        s[0].rvalid = 1'b0;
        #1;
        checks++;
        if (mo.arready !== 1'b1) begin errors++; $display("FAIL os_reopen got %b exp 1", mo.arready); end
        tick();
        q.push_back(nid);
        m.arvalid = 1'b0;
        for (int g = 0; g < 40 && q.size() > 0; g++) begin
            s[0].rvalid = 1'b1; s[0].rid = q[0]; s[0].rdata = $urandom; s[0].rlast = 1'b1;
            m.rready = 1'($urandom);
            #1;
            checks++;
            if (mo.rvalid !== 1'b1 || mo.rid !== q[0] || mo.rdata !== s[0].rdata) begin
                errors++; $display("FAIL os_drain got %b %h exp 1 %h", mo.rvalid, mo.rid, q[0]);
            end
            tick();
            if (m.rready) void'(q.pop_front());
        end
        clear();
        #1;
        checks++;
        if (q.size() != 0 || int'(dut.rcnt) != 0) begin
            errors++; $display("FAIL os_end left %0d rcnt %0d exp 0 0", q.size(), dut.rcnt);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d = $urandom;
        m.arvalid = 1'b1; m.araddr = 32'h8000_0100; m.arid = 4'd3; s[0].arready = 1'b1;
        tick();
        s[0].arready = 1'b0;
        m.araddr = 32'h2000_0000 | ($urandom & 32'hFFFF); m.arid = 4'd7; s[2].arready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (so[2].arvalid !== 1'b0 || mo.arready !== 1'b0) begin
                errors++; $display("FAIL st_hold got %b %b exp 0 0", so[2].arvalid, mo.arready);
            end
            tick();
        end
        s[0].rvalid = 1'b1; s[0].rid = 4'd3; s[0].rlast = 1'b1; m.rready = 1'b1;
        #1;
        checks++;
        if (so[2].arvalid !== 1'b0) begin errors++; $display("FAIL st_samecyc got %b exp 0", so[2].arvalid); end
        tick();
        s[0].rvalid = 1'b0;
        #1;
        checks++;
        if (so[2].arvalid !== 1'b1 || mo.arready !== 1'b1) begin
            errors++; $display("FAIL st_release got %b %b exp 1 1", so[2].arvalid, mo.arready);
        end
        tick();
        m.arvalid = 1'b0; s[2].arready = 1'b0;
        s[2].rvalid = 1'b1; s[2].rdata = d; s[2].rid = 4'd7; s[2].rlast = 1'b1;
        #1;
        checks++;
        if (mo.rvalid !== 1'b1 || mo.rdata !== d || mo.rid !== 4'd7) begin
            errors++; $display("FAIL st_slv2 got %b %h %h exp 1 %h 7", mo.rvalid, mo.rdata, mo.rid, d);
        end
        tick();
        clear();
        tick();
    endtask

    task automatic test_decerr_read(input logic [7:0] len, input logic [3:0] id);
        int b = 0;
        m.arvalid = 1'b1; m.araddr = 32'h4000_0000; m.arlen = len; m.arid = id;
        #1;
        checks++;
        if (mo.arready !== 1'b1 || mo.rvalid !== 1'b0 || so !== '0) begin
            errors++; $display("FAIL de_ar arready %b rvalid %b exp 1 0", mo.arready, mo.rvalid);
        end
        tick();
        m.arvalid = 1'b0;
        for (int g = 0; g < 100 && b <= int'(len); g++) begin
            m.rready = 1'($urandom);
            #1;
            checks++;
            if (mo.rvalid !== 1'b1 || mo.rid !== id || mo.rdata !== 32'h0 ||
                mo.rresp !== 2'b11 || mo.rlast !== (b == int'(len))) begin
                errors++; $display("FAIL de_beat%0d got %b %h %h %b %b exp 1 %h 0 11 %b",
                                   b, mo.rvalid, mo.rid, mo.rdata, mo.rresp, mo.rlast, id, b == int'(len));
            end
            tick();
            if (m.rready) b++;
        end
        m.rready = 1'b0;
        #1;
        checks++;
        if (b != int'(len) + 1 || mo.rvalid !== 1'b0) begin
            errors++; $display("FAIL de_rend beats %0d rvalid %b exp %0d 0", b, mo.rvalid, int'(len) + 1);
        end
    endtask

    task automatic test_decerr_write();
        logic [3:0] id = 4'($urandom);
        m.awvalid = 1'b1; m.awaddr = 32'h4000_0000; m.awid = id;
        #1;
        checks++;
        if (mo.awready !== 1'b1 || so !== '0) begin
            errors++; $display("FAIL dw_aw got %b exp 1", mo.awready);
        end
        tick();
        m.awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m.wvalid = 1'b1; m.wdata = $urandom; m.wlast = (b == 1);
            #1;
            checks++;
            if (mo.wready !== 1'b1 || mo.bvalid !== 1'b0 || so !== '0) begin
                errors++; $display("FAIL dw_w%0d wready %b bvalid %b exp 1 0", b, mo.wready, mo.bvalid);
            end
            tick();
        end
        m.wvalid = 1'b0; m.wlast = 1'b0; m.bready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (mo.bvalid !== 1'b1 || mo.bid !== id || mo.bresp !== 2'b11) begin
                errors++; $display("FAIL dw_b got %b %h %b exp 1 %h 11", mo.bvalid, mo.bid, mo.bresp, id);
            end
            tick();
        end
        m.bready = 1'b1;
        tick();
        m.bready = 1'b0;
        #1;
        checks++;
        if (mo.bvalid !== 1'b0) begin errors++; $display("FAIL dw_bend got %b exp 0", mo.bvalid); end
        tick();
    endtask

    task automatic test_reset_mid();
        m.arvalid = 1'b1; m.araddr = 32'h8000_0040; s[0].arready = 1'b1;
        tick(); tick();
        m.arvalid = 1'b0; s[0].arready = 1'b0;
        #1;
        checks++;
        if (int'(dut.rcnt) != 2) begin errors++; $display("FAIL rm_pre rcnt got %0d exp 2", dut.rcnt); end
        rst = 1'b0;
        m.rready = 1'b1; s[0].rvalid = 1'b1; s[0].rlast = 1'b1;
        tick();
        checks++;
        if (mo !== '0 || so !== '0 || int'(dut.rcnt) != 0) begin
            errors++; $display("FAIL rm_rst mst %h rcnt %0d exp 0 0", mo, dut.rcnt);
        end
        clear();
        rst = 1'b1;
        tick();
        test_read(32'h1000_0040, 1);
    endtask

    initial begin
        clear();
        test_reset();
        test_decode();
        test_read(32'h8000_0010, 0);
        test_write();
        test_outstanding();
        test_stall();
        test_decerr_read(8'd3, 4'd5);
        test_decerr_read(8'($urandom_range(0, 7)), 4'($urandom));
        test_decerr_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
